// File: rtl/delta_sigma_adc_pkg.sv
// delta_sigma_adc_pkg: shared constants and arithmetic helpers
// for the pulse-density modulator and its integrators.
package delta_sigma_adc_pkg;

    localparam int ORDER_FIRST  = 1;
    localparam int ORDER_SECOND = 2;
    localparam int W_MIN        = 4;
    localparam int W_MAX        = 32;

    // Full-scale magnitude 2^(w-1) of a w-bit signed quantity.
    function automatic logic signed [63:0] fs_w(input int w);
        return 64'sd1 <<< (w - 1);
    endfunction

    // Two's complement to offset binary: flip bit w-1.
    function automatic logic [31:0] offset_bin(
        input logic [31:0] x,
        input int          w
    );
        return x ^ (32'd1 << (w - 1));
    endfunction

    // a + b clamped to the range of a w-bit signed register.
    // Widths up to 62 bits are safe in the 64-bit working value.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 w
    );
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = fs_w(w) - 64'sd1;
        lo = -fs_w(w);
        s  = a + b;
        if (s > hi) begin
            return hi;
        end
        if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/delta_sigma_adc_sdm_integrator.sv
// sdm_integrator: saturating signed accumulator, WD bits wide.
// Exposes both the held state and the value it loads next edge.
module sdm_integrator #(
    parameter int WD = 18
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [WD-1:0] i_inc,
    output logic signed [WD-1:0] o_acc,
    output logic signed [WD-1:0] o_nxt
);
    import delta_sigma_adc_pkg::*;

    logic signed [WD-1:0] r_acc;

    assign o_nxt = WD'(sat_add(64'(r_acc), 64'(i_inc), WD));
    assign o_acc = r_acc;

    // Integrate with clamping so the loop never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else begin
            r_acc <= o_nxt;
        end
    end

endmodule

// File: rtl/delta_sigma_adc.sv
// delta_sigma_adc: 1-bit pulse-density modulator for a signed
// sample stream; first-order (exact) or second-order CIFB loop.
module delta_sigma_adc #(
    parameter int W     = 16,
    parameter int ORDER = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic signed [W-1:0] din,
    output logic                dout
);
    import delta_sigma_adc_pkg::*;

    logic w_q;
    logic r_dout;

    if (W < W_MIN || W > W_MAX) begin : g_bad_w
        $error("delta_sigma_adc: W must lie in 4..32");
    end

    if (ORDER == ORDER_FIRST) begin : g_o1
        logic [W-1:0] w_u;
        logic [W-1:0] r_acc;
        logic [W:0]   w_sum;

        assign w_u   = W'(offset_bin(32'(din), W));
        assign w_sum = {1'b0, r_acc} + {1'b0, w_u};
        assign w_q   = w_sum[W];

        // Phase accumulator; its carry out is the next pulse.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_acc <= '0;
            end else begin
                r_acc <= w_sum[W-1:0];
            end
        end

    end else if (ORDER == ORDER_SECOND) begin : g_o2
        localparam int W1 = W + 2;
        localparam int W2 = W + 4;
        localparam logic signed [63:0] FS = fs_w(W);

        logic signed [W1-1:0] w_v1;
        logic signed [W1-1:0] w_inc1;
        logic signed [W1-1:0] w_i1;
        logic signed [W1-1:0] w_i1_nxt;
        logic signed [W2-1:0] w_v2;
        logic signed [W2-1:0] w_inc2;
        logic signed [W2-1:0] w_i2;
        logic signed [W2-1:0] w_i2_nxt;
        logic                 w_unused;

        // Feedback DAC level follows the bit already on dout.
        assign w_v1   = r_dout ? W1'(FS) : -W1'(FS);
        assign w_v2   = r_dout ? W2'(FS) : -W2'(FS);
        assign w_inc1 = W1'(din) - w_v1;
        assign w_inc2 = W2'(w_i1) - w_v2;

        sdm_integrator #(
            .WD(W1)
        ) u_i1 (
            .clk   (clk),
            .rst_n (rst_n),
            .i_inc (w_inc1),
            .o_acc (w_i1),
            .o_nxt (w_i1_nxt)
        );

        sdm_integrator #(
            .WD(W2)
        ) u_i2 (
            .clk   (clk),
            .rst_n (rst_n),
            .i_inc (w_inc2),
            .o_acc (w_i2),
            .o_nxt (w_i2_nxt)
        );

        // Quantiser: 1 when the second integrator lands >= 0.
        assign w_q      = ~w_i2_nxt[W2-1];
        assign w_unused = ^{w_i1_nxt, w_i2};

    end else begin : g_bad_order
        assign w_q = 1'b0;
        $error("delta_sigma_adc: ORDER must be 1 or 2");
    end

    // Output bit register; cleared at once by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout <= 1'b0;
        end else begin
            r_dout <= w_q;
        end
    end

    assign dout = r_dout;

endmodule

// File: tb/tb_delta_sigma_adc.sv
// tb_delta_sigma_adc: scoreboard bench; eleven instances run in
// parallel, windows of ones-counts checked against directed values.
module tb_delta_sigma_adc;

    localparam int W    = 16;
    localparam int ND   = 11;
    localparam int NMAX = 65600;
    localparam int URST = 37428;

    typedef struct {
        string nm;
        int    d;
        int    lo;
        int    hi;
        int    elo;
        int    ehi;
        bit    mono;
    } item_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                rst_r;
    logic signed [W-1:0] din [ND];
    logic [ND-1:0]       dout;

    item_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    n [ND];
    bit    ok [ND];
    int    pre [ND][NMAX+1];
    bit    clr5 = 1'b0;
    int    last_ramp = -1;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int ORD = (g < 6) ? 1 : 2;
        delta_sigma_adc #(
            .W     (W),
            .ORDER (ORD)
        ) u_dut (
            .clk   (clk),
            .rst_n ((g == 5) ? rst_r : rst_n),
            .din   (din[g]),
            .dout  (dout[g])
        );
    end

    function automatic int fcnt(input int u, input int lo, input int hi);
        longint a;
        longint b;
        a = (longint'(hi) * u) >>> 16;
        b = (longint'(lo - 1) * u) >>> 16;
        return int'(a - b);
    endfunction

    task automatic push(input string nm, input int d, input int lo,
                        input int hi, input int elo, input int ehi,
                        input bit mono);
        item_t it;
        it.nm   = nm;
        it.d    = d;
        it.lo   = lo;
        it.hi   = hi;
        it.elo  = elo;
        it.ehi  = ehi;
        it.mono = mono;
        sb.push_back(it);
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < ND; d++) begin
            ok[d] = (d == 5) ? rst_r : rst_n;
        end
    end

    always @(negedge rst_r) clr5 = 1'b1;

    always @(negedge clk) begin
        int  i;
        int  c;
        bit  rs;
        for (int d = 0; d < ND; d++) begin
            rs = (d == 5) ? rst_r : rst_n;
            if (d == 5 && clr5) begin
                n[d] = 0;
                clr5 = 1'b0;
            end
            if (!rs) begin
                n[d] = 0;
            end else if (ok[d]) begin
                ok[d] = 1'b0;
                if (n[d] < NMAX) begin
                    n[d] = n[d] + 1;
                    pre[d][n[d]] = pre[d][n[d]-1] + int'(dout[d]);
                end
            end
        end
        i = 0;
        while (i < sb.size()) begin
            rs = (sb[i].d == 5) ? rst_r : rst_n;
            if (rs && n[sb[i].d] == sb[i].hi) begin
                c = pre[sb[i].d][sb[i].hi] - pre[sb[i].d][sb[i].lo-1];
                checks++;
                if (c < sb[i].elo || c > sb[i].ehi) begin
                    errors++;
                    $display("FAIL %s: ones=%0d required %0d..%0d",
                             sb[i].nm, c, sb[i].elo, sb[i].ehi);
                end
                if (sb[i].mono) begin
                    checks++;
                    if (c < last_ramp) begin
                        errors++;
                        $display("FAIL %s_mono: ones=%0d required >=%0d",
                                 sb[i].nm, c, last_ramp);
                    end
                    last_ramp = c;
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        rst_r   = 1'b0;
        din[0]  = 16'(-32768);
        din[1]  = 16'(0);
        din[2]  = 16'(-16384);
        din[3]  = 16'(32767);
        din[4]  = 16'(-32768);
        din[5]  = 16'(4660);
        din[6]  = 16'(-24576);
        din[7]  = 16'(0);
        din[8]  = 16'(24576);
        din[9]  = 16'(32767);
        din[10] = 16'(-32768);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (dout !== '0) begin
            errors++;
            $display("FAIL reset_dout: got %b required %b", dout, 11'b0);
        end

        for (int b = 1; b <= 8; b++) begin
            push($sformatf("min_bit%0d", b), 0, b, b, 0, 0, 1'b0);
            push($sformatf("zero_bit%0d", b), 1, b, b,
                 (b % 2 == 0) ? 1 : 0, (b % 2 == 0) ? 1 : 0, 1'b0);
            push($sformatf("quarter_bit%0d", b), 2, b, b,
                 (b % 4 == 0) ? 1 : 0, (b % 4 == 0) ? 1 : 0, 1'b0);
            push($sformatf("max_bit%0d", b), 3, b, b,
                 (b == 1) ? 0 : 1, (b == 1) ? 0 : 1, 1'b0);
        end
        push("min_window", 0, 1, 65536, 0, 0, 1'b0);
        push("zero_window", 1, 1, 65536, 32768, 32768, 1'b0);
        push("quarter_window", 2, 1, 65536, 16384, 16384, 1'b0);
        push("max_window", 3, 1, 65536, 65535, 65535, 1'b0);
        for (int b = 1; b <= 24; b++) begin
            push($sformatf("rst_first_bit%0d", b), 5, b, b,
                 fcnt(URST, b, b), fcnt(URST, b, b), 1'b0);
        end
        push("rst_first_window", 5, 1, 64, 36, 36, 1'b0);
        push("o2_m24576", 6, 1, 65536, 8190, 8194, 1'b0);
        push("o2_zero", 7, 1, 65536, 32766, 32770, 1'b0);
        push("o2_p24576", 8, 1, 65536, 57342, 57346, 1'b0);
        push("o2_fs_pos", 9, 1, 65536, 65533, 65537, 1'b0);
        push("o2_fs_neg", 10, 1, 65536, -2, 2, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        rst_r = 1'b1;

        fork
            begin
                for (int k = 0; k < 64; k++) begin
                    din[4] = 16'(-32768 + k * 1000);
                    push($sformatf("ramp_w%0d", k), 4,
                         k * 1024 + 1, (k + 1) * 1024,
                         (k * 1000 - 1) / 64,
                         (k * 1000 + 64) / 64, 1'b1);
                    repeat (1024) @(negedge clk);
                end
            end
            begin
                repeat (100) @(negedge clk);
                #2;
                checks++;
                if (dout[5] !== 1'(fcnt(URST, 100, 100))) begin
                    errors++;
                    $display("FAIL rst_pre: got %b required %0d",
                             dout[5], fcnt(URST, 100, 100));
                end
                rst_r = 1'b0;
                #1;
                checks++;
                if (dout[5] !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_async: got %b required 0", dout[5]);
                end
                #1;
                rst_r = 1'b1;
                for (int b = 1; b <= 24; b++) begin
                    push($sformatf("rst_again_bit%0d", b), 5, b, b,
                         fcnt(URST, b, b), fcnt(URST, b, b), 1'b0);
                end
                push("rst_again_window", 5, 1, 4096, 2339, 2339, 1'b0);
            end
            begin
                repeat (66000) @(negedge clk);
            end
        join

        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d required 0", sb.size());
        end
        while (sb.size() != 0) begin
            errors++;
            $display("FAIL timeout %s: reached edge %0d required %0d",
                     sb[0].nm, n[sb[0].d], sb[0].hi);
            void'(sb.pop_front());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
